multicycle_ctrl: RTL and testbench

- Moore-style control FSM that sequences the shared LEGv8 datapath (one ALU, one register file, separate instruction/data memory ports) over several cycles per instruction.
- Supports the same subset the single-cycle decoder handles: LDUR, STUR, CBZ, ADD, SUB, AND, ORR.
- Adds ready-based wait handshakes on both memory ports and a retired-instruction counter.
- Sits between the instruction register (IR) output and the datapath control inputs.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/op_classify.sv | 22 ++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 control FSM.
// S_TRAP is only reachable when ILLEGAL_OP_TRAP_EN is defined.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_MEM = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ only fixes the top 8 opcode bits; the low 3 belong to the offset
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_LD  = 3'd1,
    CLS_ST  = 3'd2,
    CLS_CB  = 3'd3,
    CLS_ILL = 3'd4
  } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: maps IR[31:21] to an instruction class.
module op_classify
  import ctrl_pkg::*;
(
  input  logic [10:0] op,
  output op_class_t   op_class
);

  always_comb begin
    op_class = CLS_ILL;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      op_class = CLS_R;
    end else if (op == OP_LDUR) begin
      op_class = CLS_LD;
    end else if (op == OP_STUR) begin
      op_class = CLS_ST;
    end else if (op[10:3] == OP_CBZ_PFX) begin
      op_class = CLS_CB;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the shared LEGv8 datapath, with memory ready
// handshakes and a retired-instruction counter. Optional: ILLEGAL_OP_TRAP_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             IMemRead,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state_o,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic             exc,
`endif
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             store_q, store_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  op_class_t        op_class;

  op_classify u_op_classify (
    .op       (Op),
    .op_class (op_class)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      store_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    retire   = 1'b0;
    IMemRead = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = ALUOP_ADD;
`ifdef ILLEGAL_OP_TRAP_EN
    exc      = 1'b0;
`endif

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        IMemRead = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_class)
          CLS_R:  state_d = S_EXEC_R;
          CLS_LD: begin
            store_d = 1'b0;
            state_d = S_ADDR;
          end
          CLS_ST: begin
            store_d = 1'b1;
            state_d = S_ADDR;
          end
          CLS_CB: state_d = S_BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
          default: state_d = S_TRAP;
`else
          // PC already advanced in FETCH, so an unknown opcode acts as a NOP
          default: state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: begin
        ALUOp   = ALUOP_FUNCT;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        ALUOp    = ALUOP_FUNCT;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = store_q;
        state_d = store_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
        if (dmem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        Reg2Loc  = 1'b1;
        ALUSrc   = 1'b1;
        if (dmem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        Reg2Loc = 1'b1;
        ALUOp   = ALUOP_PASS;
        PCWrite = Zero;
        PCSrc   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: exc = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase

    retired_d = retired_q + CNT_W'(retire);
  end

  assign state_o = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-instruction latency, retire and
// per-output active-cycle counts, plus hand sequences for trap, reset and wrap.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] Op = '0;
  logic        Zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;

  logic        IMemRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc;
  logic        MemtoReg, RegWrite, MemRead, MemWrite;
  logic [1:0]  ALUOp;
  logic [3:0]  state_o;
  logic [31:0] retired;

  logic        s_IMemRead, s_IRWrite, s_PCWrite, s_PCSrc, s_Reg2Loc, s_ALUSrc;
  logic        s_MemtoReg, s_RegWrite, s_MemRead, s_MemWrite;
  logic [1:0]  s_ALUOp;
  logic [3:0]  s_state_o;
  logic [2:0]  retired_s;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        exc, s_exc;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemRead(IMemRead), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .state_o(state_o),
`ifdef ILLEGAL_OP_TRAP_EN
    .exc(exc),
`endif
    .retired(retired)
  );

  // Narrow-counter instance sharing all stimulus, used to exercise the wrap
  multicycle_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemRead(s_IMemRead), .IRWrite(s_IRWrite), .PCWrite(s_PCWrite), .PCSrc(s_PCSrc),
    .Reg2Loc(s_Reg2Loc), .ALUSrc(s_ALUSrc), .MemtoReg(s_MemtoReg), .RegWrite(s_RegWrite),
    .MemRead(s_MemRead), .MemWrite(s_MemWrite), .ALUOp(s_ALUOp), .state_o(s_state_o),
`ifdef ILLEGAL_OP_TRAP_EN
    .exc(s_exc),
`endif
    .retired(retired_s)
  );

  // Bit 11 = IMemRead ... bit 0 = ALUOp[0]
  logic [11:0] sig_vec;
  assign sig_vec = {IMemRead, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc,
                    MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1], ALUOp[0]};

  // cnts: one hex digit per output, MSB digit = IMemRead ... LSB digit = ALUOp[0]
  typedef struct packed {
    logic [10:0] op;
    logic        zero;
    logic [3:0]  iw;
    logic [3:0]  dw;
    logic [4:0]  lat;
    logic        ret;
    logic [47:0] cnts;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  int passed = 0;
  int total  = 0;
  int model_ret = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int cnt [12];
    int cyc, fw, mw;
    logic left;
    logic [3:0] st;
    logic [31:0] r0;
    v = tbl[idx];
    foreach (cnt[i]) cnt[i] = 0;
    cyc = 0; fw = 0; mw = 0; left = 1'b0;
    r0 = retired;
    Op = v.op;
    Zero = v.zero;
    while (!(left && state_o == S_FETCH) && cyc < 40) begin
      st = state_o;
      imem_ready = !(st == S_FETCH && fw < int'(v.iw));
      dmem_ready = !((st == S_MEM_RD || st == S_MEM_WR) && mw < int'(v.dw));
      #1;
      for (int i = 0; i < 12; i++) cnt[i] += int'(sig_vec[11-i]);
      if (st == S_FETCH && !imem_ready) fw++;
      if ((st == S_MEM_RD || st == S_MEM_WR) && !dmem_ready) mw++;
      if (st != S_FETCH) left = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_latency", idx), cyc, int'(v.lat));
    chk($sformatf("v%0d_retire", idx), retired - r0, int'(v.ret));
    for (int i = 0; i < 12; i++)
      chk($sformatf("v%0d_cnt%0d", idx, i), cnt[i], int'(v.cnts[(11-i)*4 +: 4]));
    model_ret += int'(v.ret);
    $display("vec %0d op=%b zero=%0d iw=%0d dw=%0d: latency=%0d retired=%0d",
             idx, v.op, v.zero, v.iw, v.dw, cyc, retired);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{OP_ADD,         1'b0, 4'd0, 4'd0, 5'd4, 1'b1, 48'h111000010020};
    tbl[1]  = '{OP_SUB,         1'b0, 4'd2, 4'd0, 5'd6, 1'b1, 48'h311000010020};
    tbl[2]  = '{OP_AND,         1'b0, 4'd0, 4'd0, 5'd4, 1'b1, 48'h111000010020};
    tbl[3]  = '{OP_ORR,         1'b0, 4'd1, 4'd0, 5'd5, 1'b1, 48'h211000010020};
    tbl[4]  = '{OP_LDUR,        1'b0, 4'd0, 4'd3, 5'd8, 1'b1, 48'h111005114000};
    tbl[5]  = '{OP_LDUR,        1'b0, 4'd0, 4'd0, 5'd5, 1'b1, 48'h111002111000};
    tbl[6]  = '{OP_STUR,        1'b0, 4'd0, 4'd0, 5'd4, 1'b1, 48'h111022000100};
    tbl[7]  = '{OP_STUR,        1'b0, 4'd1, 4'd2, 5'd7, 1'b1, 48'h211044000300};
    tbl[8]  = '{11'b10110100101, 1'b1, 4'd0, 4'd0, 5'd3, 1'b1, 48'h112110000001};
    tbl[9]  = '{11'b10110100000, 1'b0, 4'd0, 4'd0, 5'd3, 1'b1, 48'h111110000001};
    tbl[10] = '{11'b11111111111, 1'b0, 4'd0, 4'd0, 5'd2, 1'b0, 48'h111000000000};

    // Reset state
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #3;
    chk("reset_state", state_o, S_IDLE);
    chk("reset_outputs", sig_vec, 0);
    chk("reset_retired", retired, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("idle_state", state_o, S_IDLE);
    chk("idle_outputs", sig_vec, 0);
    @(posedge clk);
    @(negedge clk);
    chk("first_fetch", state_o, S_FETCH);
    $display("reset released: state=%0d retired=%0d", state_o, retired);

    for (int i = 0; i < NV; i++) begin
`ifdef ILLEGAL_OP_TRAP_EN
      if (tbl[i].op == 11'b11111111111) continue;
`endif
      run_vec(i);
    end
    chk("total_retired", retired, model_ret);

    // Bring the 3-bit counter to its maximum, then one STUR must wrap it
    n = 0;
    while ((model_ret % 8) != 7 && n < 8) begin
      run_vec(9);
      n++;
    end
    chk("wrap_pre", retired_s, 7);
    run_vec(6);
    chk("wrap_post", retired_s, 0);
    $display("wrap: retired_s=%0d retired=%0d", retired_s, retired);

`ifdef ILLEGAL_OP_TRAP_EN
    begin
      logic [31:0] r0;
      r0 = retired;
      Op = 11'b11111111111;
      imem_ready = 1'b1;
      n = 0;
      while (state_o != S_TRAP && n < 5) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      for (int c = 0; c < 5; c++) begin
        chk("trap_state", state_o, S_TRAP);
        chk("trap_exc", exc, 1);
        chk("trap_outputs", sig_vec, 0);
        @(posedge clk);
        @(negedge clk);
      end
      chk("trap_retired", retired, r0);
      $display("trap: state=%0d exc=%0d retired=%0d", state_o, exc, retired);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
`endif

    // Reset in the middle of a store wait aborts without retiring
    Op = OP_STUR;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    n = 0;
    while (state_o != S_MEM_WR && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("memwr_reached", state_o, S_MEM_WR);
    chk("memwr_write", MemWrite, 1);
    @(posedge clk);
    @(negedge clk);
    chk("memwr_hold", state_o, S_MEM_WR);
    chk("memwr_write_hold", MemWrite, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_write", MemWrite, 0);
    chk("abort_state", state_o, S_IDLE);
    chk("abort_retired", retired, 0);
    chk("abort_retired_s", retired_s, 0);
    $display("abort: state=%0d MemWrite=%0d retired=%0d", state_o, MemWrite, retired);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("refetch", state_o, S_FETCH);
    model_ret = 0;
    run_vec(0);
    chk("after_abort_retired", retired, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
